// File: rtl/watchdog_multi.sv
// rtl/watchdog_multi.sv - multi-channel heartbeat watchdog with first-fault latch and global reset pulse.
// Optional heartbeat window check (early kick counts as a fault) is enabled by defining WD_WINDOW_EN.
module watchdog_multi #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 100000000,
  parameter int WARN_AT  = 75000000,
  parameter int RST_HOLD = 16,
  parameter int WIN_MIN  = 1000,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] heartbeat,
  input  logic              clear,
  output logic [NUM_CH-1:0] warning,
  output logic [NUM_CH-1:0] expired,
  output logic [NUM_CH-1:0] early_hb,
  output logic              force_reset,
  output logic              fault_valid,
  output logic [CH_W-1:0]   fault_ch
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_WARN = CNT_W'(WARN_AT);
`ifdef WD_WINDOW_EN
  localparam logic [CNT_W-1:0] CNT_WIN  = CNT_W'(WIN_MIN);
`endif

  if (NUM_CH < 1 || NUM_CH > 16 || WARN_AT < 1 || WARN_AT >= TIMEOUT ||
      RST_HOLD < 1 || WIN_MIN >= WARN_AT) begin : g_param_err
    $error("watchdog_multi: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXPIRED} state_t;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] warn_d;
  logic [NUM_CH-1:0] exp_d;
  logic [NUM_CH-1:0] early_d;
  logic [NUM_CH-1:0] new_exp;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              too_early;
  logic [CH_W-1:0]   first_ch;
  logic [HOLD_W-1:0] hold_q;
  logic              clr_ok;

  // clear is locked out while the reset pulse is in flight
  assign clr_ok = clear & ~force_reset;

  always_comb begin
    cnt_nxt   = '0;
    too_early = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      warn_d[i]  = warning[i];
      exp_d[i]   = expired[i];
      early_d[i] = 1'b0;
      new_exp[i] = 1'b0;
      cnt_nxt    = heartbeat[i] ? '0 : cnt_q[i] + CNT_W'(1);
`ifdef WD_WINDOW_EN
      // the IDLE->RUN edge samples in IDLE, so its heartbeat is exempt
      too_early  = (state_q[i] == S_RUN) && heartbeat[i] && (cnt_q[i] < CNT_WIN);
`else
      too_early  = 1'b0;
`endif
      if (clr_ok) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
        warn_d[i]  = 1'b0;
        exp_d[i]   = 1'b0;
      end else if (state_q[i] != S_EXPIRED) begin
        if (!enable[i]) begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
          warn_d[i]  = 1'b0;
        end else if (too_early) begin
          state_d[i] = S_EXPIRED;
          cnt_d[i]   = CNT_TO;
          warn_d[i]  = 1'b1;
          exp_d[i]   = 1'b1;
          early_d[i] = 1'b1;
          new_exp[i] = 1'b1;
        end else begin
          cnt_d[i]   = cnt_nxt;
          warn_d[i]  = (cnt_nxt >= CNT_WARN);
          if (cnt_nxt == CNT_TO) begin
            state_d[i] = S_EXPIRED;
            exp_d[i]   = 1'b1;
            new_exp[i] = 1'b1;
          end else begin
            state_d[i] = S_RUN;
          end
        end
      end
    end
  end

  always_comb begin
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (new_exp[i]) first_ch = CH_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      warning     <= '0;
      expired     <= '0;
      early_hb    <= '0;
      force_reset <= 1'b0;
      fault_valid <= 1'b0;
      fault_ch    <= '0;
      hold_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      warning  <= warn_d;
      expired  <= exp_d;
      early_hb <= early_d;
      if (clr_ok) begin
        fault_valid <= 1'b0;
        fault_ch    <= '0;
      end else if (!fault_valid && (|new_exp)) begin
        fault_valid <= 1'b1;
        fault_ch    <= first_ch;
        force_reset <= 1'b1;
        hold_q      <= HOLD_W'(RST_HOLD - 1);
      end else if (force_reset) begin
        if (hold_q == '0) force_reset <= 1'b0;
        else              hold_q      <= hold_q - HOLD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_watchdog_multi.sv
// tb/tb_watchdog_multi.sv - directed self-checking bench for watchdog_multi (2 channels, short timeouts).
// Window-check expectations switch on WD_WINDOW_EN.
module tb_watchdog_multi;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] enable;
  logic [1:0] heartbeat;
  logic       clear;
  logic [1:0] warning;
  logic [1:0] expired;
  logic [1:0] early_hb;
  logic       force_reset;
  logic       fault_valid;
  logic [0:0] fault_ch;

  int checks = 0;
  int failures = 0;
  logic [1:0] acc_warn;
  logic [1:0] acc_exp;
  logic       acc_fr;

  watchdog_multi #(
    .NUM_CH(2), .CNT_W(8), .TIMEOUT(8), .WARN_AT(6), .RST_HOLD(3), .WIN_MIN(3)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .heartbeat(heartbeat), .clear(clear),
    .warning(warning), .expired(expired), .early_hb(early_hb),
    .force_reset(force_reset), .fault_valid(fault_valid), .fault_ch(fault_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; enable = 2'b00; heartbeat = 2'b00; clear = 1'b0;
    repeat (3) tick();
    chk("rst_warning", warning, 0);
    chk("rst_expired", expired, 0);
    chk("rst_early", early_hb, 0);
    chk("rst_force", force_reset, 0);
    chk("rst_fvalid", fault_valid, 0);
    chk("rst_fch", fault_ch, 0);

    // single channel timeout from reset release
    rstn = 1'b1; enable = 2'b01;
    repeat (5) tick();
    chk("t1_warn_e5", warning, 0);
    tick();
    chk("t1_warn_e6", warning, 1);
    tick();
    chk("t1_exp_e7", expired, 0);
    chk("t1_force_e7", force_reset, 0);
    tick();
    chk("t1_exp_e8", expired, 1);
    chk("t1_fvalid_e8", fault_valid, 1);
    chk("t1_fch_e8", fault_ch, 0);
    chk("t1_force_e8", force_reset, 1);
    chk("t1_warn_e8", warning, 1);
    tick();
    chk("t1_force_e9", force_reset, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t1_force_e10", force_reset, 1);
    chk("t1_clr_ignored_exp", expired, 1);
    chk("t1_clr_ignored_fv", fault_valid, 1);
    tick();
    chk("t1_force_e11", force_reset, 0);
    chk("t1_exp_sticky", expired, 1);
    enable = 2'b00; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t1_clr_exp", expired, 0);
    chk("t1_clr_fv", fault_valid, 0);
    chk("t1_clr_fch", fault_ch, 0);
    chk("t1_clr_warn", warning, 0);

    // regular heartbeats keep the channel healthy
    enable = 2'b01; acc_warn = 2'b00; acc_exp = 2'b00; acc_fr = 1'b0;
    for (int k = 0; k < 100; k++) begin
      heartbeat = (k % 5 == 4) ? 2'b01 : 2'b00;
      tick();
      acc_warn = acc_warn | warning;
      acc_exp  = acc_exp | expired;
      acc_fr   = acc_fr | force_reset;
    end
    heartbeat = 2'b00; enable = 2'b00;
    tick();
    chk("t2_no_warn", acc_warn, 0);
    chk("t2_no_exp", acc_exp, 0);
    chk("t2_no_force", acc_fr, 0);

    // both channels expire together
    enable = 2'b11;
    repeat (7) tick();
    chk("t3_exp_e7", expired, 0);
    tick();
    chk("t3_exp_e8", expired, 3);
    chk("t3_fch", fault_ch, 0);
    chk("t3_fvalid", fault_valid, 1);
    chk("t3_force_e8", force_reset, 1);
    repeat (2) tick();
    chk("t3_force_e10", force_reset, 1);
    tick();
    chk("t3_force_e11", force_reset, 0);
    repeat (3) tick();
    chk("t3_force_no_repeat", force_reset, 0);
    enable = 2'b00; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_clr_exp", expired, 0);
    chk("t3_clr_fv", fault_valid, 0);

    // channel 1 first, later channel 0 must not overwrite the latch
    enable = 2'b10;
    repeat (8) tick();
    chk("t3b_exp", expired, 2);
    chk("t3b_fch", fault_ch, 1);
    chk("t3b_force", force_reset, 1);
    enable = 2'b11;
    repeat (8) tick();
    chk("t3b_exp_both", expired, 3);
    chk("t3b_fch_kept", fault_ch, 1);
    chk("t3b_no_restart", force_reset, 0);
    enable = 2'b00; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3b_clr_exp", expired, 0);
    chk("t3b_clr_fch", fault_ch, 0);

    // heartbeat beats the timeout on the same edge
    enable = 2'b01;
    repeat (7) tick();
    chk("t4_warn_c7", warning, 1);
    heartbeat = 2'b01;
    tick();
    heartbeat = 2'b00;
    chk("t4_hb_no_exp", expired, 0);
    chk("t4_hb_warn_low", warning, 0);
    repeat (5) tick();
    chk("t4_warn_c5", warning, 0);
    tick();
    chk("t4_warn_c6", warning, 1);
    enable = 2'b00;
    tick();
    chk("t4_idle_warn", warning, 0);

    // dropping enable restarts the count
    enable = 2'b01;
    repeat (5) tick();
    enable = 2'b00;
    tick();
    chk("t4_drop_warn", warning, 0);
    enable = 2'b01;
    repeat (5) tick();
    chk("t4_restart_warn5", warning, 0);
    chk("t4_restart_exp", expired, 0);
    tick();
    chk("t4_restart_warn6", warning, 1);
    enable = 2'b00;
    tick();

    // asynchronous reset in the middle of the pulse
    enable = 2'b01;
    repeat (8) tick();
    chk("t5_force_on", force_reset, 1);
    tick();
    #2 rstn = 1'b0;
    #1;
    chk("t5_async_force", force_reset, 0);
    chk("t5_async_fv", fault_valid, 0);
    chk("t5_async_exp", expired, 0);
    enable = 2'b00;
    tick();
    rstn = 1'b1;
    tick();

    // heartbeat at counter 1
    enable = 2'b01;
    tick();
    heartbeat = 2'b01;
    tick();
    heartbeat = 2'b00;
`ifdef WD_WINDOW_EN
    chk("t6_early", early_hb, 1);
    chk("t6_exp", expired, 1);
    chk("t6_force", force_reset, 1);
    chk("t6_fvalid", fault_valid, 1);
`else
    chk("t6_early", early_hb, 0);
    chk("t6_exp", expired, 0);
    chk("t6_force", force_reset, 0);
    chk("t6_fvalid", fault_valid, 0);
`endif
    tick();
    chk("t6_early_pulse_end", early_hb, 0);
    enable = 2'b00;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clr_exp", expired, 0);
    chk("t6_clr_force", force_reset, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
